// File: rtl/or_reduce_serial.sv
// Sequential OR-reduction engine: scans a WIDTH-bit word CHUNK bits per cycle and reports any/single/lowest-index.
// Optional macro OR_REDUCE_EARLY_EXIT_EN ends the scan as soon as a second set bit has been seen.
module or_reduce_serial #(
    parameter  int WIDTH  = 16,
    parameter  int CHUNK  = 4,
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK,
    localparam int IW     = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_any,
    output logic             out_single,
    output logic [IW-1:0]    out_idx
);

    localparam int BW = NCHUNK * CHUNK;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BW-1:0]   r_buf;
    logic [1:0]      r_cnt;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_chunk;
    logic            r_out_valid;
    logic            r_any;
    logic            r_single;
    logic [IW-1:0]   r_out_idx;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_last_chunk;
    logic            w_exit;
    logic            w_found;
    logic [IW-1:0]   w_pos;
    logic [1:0]      w_cnt_nxt;
    logic [IW-1:0]   w_idx_nxt;

    // Accept is blocked whenever reset is asserted, independent of the state register.
    assign w_in_ready   = rst_n && (r_state == S_IDLE);
    assign w_accept     = in_valid && w_in_ready;
    assign w_last_chunk = (r_chunk == CW'(NCHUNK - 1));

`ifdef OR_REDUCE_EARLY_EXIT_EN
    assign w_exit = w_last_chunk || (w_cnt_nxt == 2'd2);
`else
    assign w_exit = w_last_chunk;
`endif

    // Per-chunk evaluation: saturating bit count and lowest set position (lower index wins).
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_pos     = '0;
        w_found   = 1'b0;
        for (int b = CHUNK - 1; b >= 0; b--) begin
            w_found   = w_found | r_buf[b];
            w_pos     = r_buf[b] ? IW'(b) : w_pos;
            w_cnt_nxt = (r_buf[b] && (w_cnt_nxt != 2'd2)) ? (w_cnt_nxt + 2'd1) : w_cnt_nxt;
        end
        w_idx_nxt = (w_found && (r_cnt == 2'd0)) ? (IW'(int'(r_chunk) * CHUNK) + w_pos) : r_idx;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a DONE handshake always returns to IDLE so no accept overlaps it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_accept  ? S_SCAN : S_IDLE;
            S_SCAN:  w_state_nxt = w_exit    ? S_DONE : S_SCAN;
            S_DONE:  w_state_nxt = out_ready ? S_IDLE : S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: shift buffer, accumulators and the registered result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf       <= '0;
            r_cnt       <= 2'd0;
            r_idx       <= '0;
            r_chunk     <= '0;
            r_out_valid <= 1'b0;
            r_any       <= 1'b0;
            r_single    <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_buf   <= BW'(in_data);
                        r_cnt   <= 2'd0;
                        r_idx   <= '0;
                        r_chunk <= '0;
                    end
                end
                S_SCAN: begin
                    r_buf   <= r_buf >> CHUNK;
                    r_cnt   <= w_cnt_nxt;
                    r_idx   <= w_idx_nxt;
                    r_chunk <= r_chunk + CW'(1);
                    if (w_exit) begin
                        r_out_valid <= 1'b1;
                        r_any       <= (w_cnt_nxt != 2'd0);
                        r_single    <= (w_cnt_nxt == 2'd1);
                        r_out_idx   <= w_idx_nxt;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_any    = r_any;
    assign out_single = r_single;
    assign out_idx    = r_out_idx;

endmodule

// File: tb/tb_or_reduce_serial.sv
// Randomized self-checking bench for or_reduce_serial (16/4 and zero-padded 10/4 instances).
`timescale 1ns/1ps
module tb_or_reduce_serial;

    localparam int CH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_valid;
    logic [15:0] m_data;
    logic        out_ready;
    int          sel;

    logic        a_in_ready, a_out_valid, a_any, a_single;
    logic [3:0]  a_idx;
    logic        b_in_ready, b_out_valid, b_any, b_single;
    logic [3:0]  b_idx;

    logic        m_in_ready, m_out_valid, m_any, m_single;
    logic [3:0]  m_idx;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    or_reduce_serial #(.WIDTH(16), .CHUNK(CH)) u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (m_valid && (sel == 0)),
        .in_ready   (a_in_ready),
        .in_data    (m_data),
        .out_valid  (a_out_valid),
        .out_ready  (out_ready),
        .out_any    (a_any),
        .out_single (a_single),
        .out_idx    (a_idx)
    );

    or_reduce_serial #(.WIDTH(10), .CHUNK(CH)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (m_valid && (sel != 0)),
        .in_ready   (b_in_ready),
        .in_data    (m_data[9:0]),
        .out_valid  (b_out_valid),
        .out_ready  (out_ready),
        .out_any    (b_any),
        .out_single (b_single),
        .out_idx    (b_idx)
    );

    assign m_in_ready  = (sel != 0) ? b_in_ready  : a_in_ready;
    assign m_out_valid = (sel != 0) ? b_out_valid : a_out_valid;
    assign m_any       = (sel != 0) ? b_any       : a_any;
    assign m_single    = (sel != 0) ? b_single    : a_single;
    assign m_idx       = (sel != 0) ? b_idx       : a_idx;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain bit counting over the word, latency from the chunk holding the second set bit.
    task automatic model(input int wbits, input logic [15:0] w, output logic any, output logic single,
                         output int idx, output int lat);
        int c;
        c   = 0;
        idx = 0;
        lat = (wbits + CH - 1) / CH;
        for (int i = 0; i < wbits; i++) begin
            if (w[i]) begin
                if (c == 0) idx = i;
                c++;
`ifdef OR_REDUCE_EARLY_EXIT_EN
                if (c == 2) lat = i / CH + 1;
`endif
            end
        end
        any    = (c >= 1);
        single = (c == 1);
    endtask

    task automatic run_txn(input int s, input logic [15:0] word, input int hold, input bit force_v);
        logic        e_any, e_single;
        int          e_idx, e_lat, n;
        logic [15:0] w;
        w = (s != 0) ? (word & 16'h03FF) : word;
        model((s != 0) ? 10 : 16, w, e_any, e_single, e_idx, e_lat);
        @(negedge clk);
        sel = s; m_valid = 1'b1; m_data = w; out_ready = 1'b0;
        #1;
        n = 0;
        while (!m_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_ready", m_in_ready, 1);
        @(negedge clk);
        m_valid = force_v ? 1'b1 : 1'($urandom);
        m_data  = 16'($urandom);
        n = 0;
        while (!m_out_valid && n < 40) begin
            @(negedge clk);
            n++;
            m_valid = force_v ? 1'b1 : 1'($urandom);
            m_data  = 16'($urandom);
        end
        check_eq("latency", n, e_lat);
        check_eq("any", m_any, e_any);
        check_eq("single", m_single, e_single);
        check_eq("idx", m_idx, e_idx);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            m_valid = force_v ? 1'b1 : 1'($urandom);
            check_eq("hold_valid", m_out_valid, 1);
            check_eq("hold_ready", m_in_ready, 0);
            check_eq("hold_any", m_any, e_any);
            check_eq("hold_single", m_single, e_single);
            check_eq("hold_idx", m_idx, e_idx);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        m_valid   = 1'b0;
        check_eq("post_hs_valid", m_out_valid, 0);
        check_eq("post_hs_ready", m_in_ready, 1);
    endtask

    initial begin
        logic [15:0] w;
        int          s;
        rst_n = 1'b0; m_valid = 1'b0; m_data = 16'h0000; out_ready = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_a_valid", a_out_valid, 0);
        check_eq("rst_a_ready", a_in_ready, 0);
        check_eq("rst_a_any", a_any, 0);
        check_eq("rst_a_single", a_single, 0);
        check_eq("rst_a_idx", a_idx, 0);
        check_eq("rst_b_valid", b_out_valid, 0);
        check_eq("rst_b_ready", b_in_ready, 0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_a_ready", a_in_ready, 1);
        check_eq("rel_b_ready", b_in_ready, 1);

        run_txn(0, 16'h0000, 0, 1'b0);
        run_txn(0, 16'h0100, 0, 1'b0);
        run_txn(0, 16'h0003, 0, 1'b0);
        run_txn(0, 16'h8000, 5, 1'b1);

        // Reset in the middle of a scan: the partial result must never appear.
        @(negedge clk);
        sel = 0; m_valid = 1'b1; m_data = 16'h00F0;
        #1;
        check_eq("rst_mid_ready", a_in_ready, 1);
        @(negedge clk);
        m_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_valid", a_out_valid, 0);
        check_eq("rst_mid_any", a_any, 0);
        check_eq("rst_mid_single", a_single, 0);
        check_eq("rst_mid_idx", a_idx, 0);
        check_eq("rst_mid_inready", a_in_ready, 0);
        @(negedge clk);
        check_eq("rst_mid_valid2", a_out_valid, 0);
        rst_n = 1'b1;
        #1;
        check_eq("rst_mid_rel", a_in_ready, 1);
        run_txn(0, 16'h0001, 0, 1'b0);

        run_txn(1, 16'h0200, 0, 1'b0);
        run_txn(1, 16'h0300, 0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            s = int'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       w = 16'($urandom);
                1:       w = 16'h0000;
                2:       w = 16'h0001 << $urandom_range(0, 15);
                3:       w = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                default: w = 16'h0000;
            endcase
            run_txn(s, w, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
